// File: rtl/mcycle_issue_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// mcycle_issue_scheduler_pkg : shared thread/latency constants and tag type
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mcycle_issue_scheduler_pkg;

  localparam int THREADS_PER_CORE     = 4;
  localparam int MCYCLE_ARITH_LATENCY = 5;
  localparam int SCYCLE_ARITH_LATENCY = 1;
  localparam int THREAD_IDX_W         = $clog2(THREADS_PER_CORE);

  typedef logic [THREAD_IDX_W-1:0] thread_idx_t;

  typedef struct packed {
    logic        valid;
    logic        squashed;
    thread_idx_t thread;
  } mcycle_tag_t;

endpackage

`default_nettype wire

// File: rtl/mcycle_issue_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter, zero-latency one-hot grant plus index
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [N-1:0]     request_i,
  input  logic             update_en_i,
  output logic [N-1:0]     grant_oh_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan starts just past the last winner; N is a power of two so the add wraps.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int off = 1; off <= N; off++) begin
      w_idx = rr_ptr_q + IDX_W'(off);
      if (!w_found && request_i[w_idx]) begin
        w_found            = 1'b1;
        grant_oh_o[w_idx]  = 1'b1;
        grant_idx_o        = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= IDX_W'(N - 1);
    end else if (update_en_i && w_found) begin
      rr_ptr_q <= grant_idx_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcycle_issue_scheduler.sv
// ---------------------------------------------------------------------------
// mcycle_issue_scheduler : round-robin issue with writeback-slot reservation
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcycle_issue_scheduler
  import mcycle_issue_scheduler_pkg::*;
#(
  parameter int THREADS        = THREADS_PER_CORE,
  parameter int MCYCLE_LATENCY = MCYCLE_ARITH_LATENCY,
  parameter int SCYCLE_LATENCY = SCYCLE_ARITH_LATENCY,
  parameter int CNT_WIDTH      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [THREADS-1:0] thread_ready,
  input  logic [THREADS-1:0] thread_is_mcycle,
  input  logic [THREADS-1:0] thread_has_dest,
  input  logic               wb_rollback_en,
  input  thread_idx_t        wb_rollback_thread_idx,
  output logic [THREADS-1:0] ts_grant_oh,
  output logic               ts_grant_valid,
  output thread_idx_t        ts_grant_thread_idx,
  output logic [THREADS-1:0] ts_mcycle_pending,
  output logic               ts_wb_expect_valid,
  output thread_idx_t        ts_wb_expect_thread_idx
);

  logic [MCYCLE_LATENCY-1:1] occ_q, occ_d;
  mcycle_tag_t               tag_q [MCYCLE_LATENCY];
  mcycle_tag_t               tag_d [MCYCLE_LATENCY];
  logic [CNT_WIDTH-1:0]      cnt_q [THREADS];
  logic [CNT_WIDTH-1:0]      cnt_d [THREADS];
  logic [CNT_WIDTH-1:0]      w_dec [THREADS];
  logic [THREADS-1:0]        w_inc;
  logic [THREADS-1:0]        w_eligible;
  logic [THREADS-1:0]        w_grant_oh;
  thread_idx_t               w_grant_idx;
  logic                      w_grant_mc;
  logic                      w_grant_dest;
  logic                      w_cnt_bad;

  // Requests are gated by reset so grants are quiet while reset is held.
  generate
    for (genvar i = 0; i < THREADS; i++) begin : g_elig
      assign w_eligible[i] = reset && thread_ready[i]
          && !(wb_rollback_en && (wb_rollback_thread_idx == thread_idx_t'(i)))
          && (!thread_has_dest[i] || thread_is_mcycle[i] || !occ_q[SCYCLE_LATENCY]);
    end
  endgenerate

  rr_arbiter #(
    .N     (THREADS),
    .IDX_W ($bits(thread_idx_t))
  ) u_rr_arbiter (
    .clk         (clk),
    .rst_ni      (reset),
    .request_i   (w_eligible),
    .update_en_i (1'b1),
    .grant_oh_o  (w_grant_oh),
    .grant_idx_o (w_grant_idx)
  );

  assign w_grant_mc   = |(w_grant_oh & thread_is_mcycle);
  assign w_grant_dest = |(w_grant_oh & thread_has_dest);

  always_comb begin
    occ_d = '0;
    for (int k = 1; k <= MCYCLE_LATENCY - 2; k++) begin
      occ_d[k] = occ_q[k+1] | (w_grant_dest && !w_grant_mc && (SCYCLE_LATENCY == k + 1));
    end
    occ_d[MCYCLE_LATENCY-1] = w_grant_dest && w_grant_mc;
  end

  // Squash is applied to entries as they shift, so the moved copy carries it.
  always_comb begin
    tag_d[0] = '{valid: w_grant_mc, squashed: 1'b0, thread: w_grant_idx};
    for (int j = 1; j < MCYCLE_LATENCY; j++) begin
      tag_d[j] = tag_q[j-1];
      if (wb_rollback_en && tag_q[j-1].valid && (tag_q[j-1].thread == wb_rollback_thread_idx)) begin
        tag_d[j].squashed = 1'b1;
      end
    end
  end

  // An entry leaves the count exactly once: entering the final stage, or on squash.
  always_comb begin
    w_cnt_bad = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      w_inc[i] = w_grant_mc && (w_grant_idx == thread_idx_t'(i));
      w_dec[i] = '0;
      for (int j = 0; j <= MCYCLE_LATENCY - 2; j++) begin
        if (tag_q[j].valid && !tag_q[j].squashed && (tag_q[j].thread == thread_idx_t'(i))
            && ((j == MCYCLE_LATENCY - 2)
                || (wb_rollback_en && (wb_rollback_thread_idx == thread_idx_t'(i))))) begin
          w_dec[i] = w_dec[i] + CNT_WIDTH'(1);
        end
      end
      cnt_d[i] = cnt_q[i] + CNT_WIDTH'(w_inc[i]) - w_dec[i];
      if ((cnt_q[i] > CNT_WIDTH'(MCYCLE_LATENCY))
          || (({1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(w_inc[i])) < {1'b0, w_dec[i]})) begin
        w_cnt_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
      for (int j = 0; j < MCYCLE_LATENCY; j++) tag_q[j] <= '0;
      for (int i = 0; i < THREADS; i++) cnt_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int j = 0; j < MCYCLE_LATENCY; j++) tag_q[j] <= tag_d[j];
      for (int i = 0; i < THREADS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  generate
    for (genvar i = 0; i < THREADS; i++) begin : g_pending
      assign ts_mcycle_pending[i] = |cnt_q[i];
    end
  endgenerate

  assign ts_grant_oh             = w_grant_oh;
  assign ts_grant_valid          = |w_grant_oh;
  assign ts_grant_thread_idx     = w_grant_idx;
  assign ts_wb_expect_valid      = tag_q[MCYCLE_LATENCY-1].valid && !tag_q[MCYCLE_LATENCY-1].squashed;
  assign ts_wb_expect_thread_idx = tag_q[MCYCLE_LATENCY-1].thread;

  a_cnt_range : assert property (@(posedge clk) disable iff (!reset) !w_cnt_bad);

endmodule

`default_nettype wire

// File: tb/tb_mcycle_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mcycle_issue_scheduler : directed + random bench against a cycle model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mcycle_issue_scheduler;
  import mcycle_issue_scheduler_pkg::*;

  localparam int T     = 4;
  localparam int ML    = 5;
  localparam int SL    = 1;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [T-1:0] ready = '0, mc = '0, dest = '0;
  logic        rb_en = 1'b0;
  thread_idx_t rb_idx = '0;
  logic [T-1:0] ts_grant_oh, ts_mcycle_pending;
  logic        ts_grant_valid, ts_wb_expect_valid;
  thread_idx_t ts_grant_thread_idx, ts_wb_expect_thread_idx;

  mcycle_issue_scheduler dut (
    .clk                     (clk),
    .reset                   (reset),
    .thread_ready            (ready),
    .thread_is_mcycle        (mc),
    .thread_has_dest         (dest),
    .wb_rollback_en          (rb_en),
    .wb_rollback_thread_idx  (rb_idx),
    .ts_grant_oh             (ts_grant_oh),
    .ts_grant_valid          (ts_grant_valid),
    .ts_grant_thread_idx     (ts_grant_thread_idx),
    .ts_mcycle_pending       (ts_mcycle_pending),
    .ts_wb_expect_valid      (ts_wb_expect_valid),
    .ts_wb_expect_thread_idx (ts_wb_expect_thread_idx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: in-flight multi-cycle ops keyed by absolute issue cycle.
  typedef struct { int s; int t; int sq; } ent_t;
  ent_t q[$];
  bit   busy[int];
  int   rr = T - 1;
  int   m_g, m_cnt, m_wi;
  logic [T-1:0] m_elig, m_pend;
  logic m_wv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_grant_oh", 32'(ts_grant_oh), 0);
      chk("rst_grant_valid", 32'(ts_grant_valid), 0);
      chk("rst_pending", 32'(ts_mcycle_pending), 0);
      chk("rst_wb_valid", 32'(ts_wb_expect_valid), 0);
      chk("rst_wb_idx", 32'(ts_wb_expect_thread_idx), 0);
      q.delete();
      busy.delete();
      rr = T - 1;
    end else begin
      for (int i = 0; i < T; i++)
        m_elig[i] = ready[i] && !(rb_en && (int'(rb_idx) == i))
                    && (!dest[i] || mc[i] || !busy.exists(cyc + SL));
      m_g = -1;
      for (int off = 1; off <= T; off++)
        if (m_g < 0 && m_elig[(rr + off) % T]) m_g = (rr + off) % T;
      chk("grant_oh", 32'(ts_grant_oh), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
      chk("grant_valid", 32'(ts_grant_valid), 32'(m_g >= 0));
      if (m_g >= 0) chk("grant_idx", 32'(ts_grant_thread_idx), 32'(m_g));
      for (int i = 0; i < T; i++) begin
        m_cnt = 0;
        foreach (q[k])
          if (q[k].t == i && q[k].s < cyc && cyc < q[k].s + ML && q[k].sq >= cyc) m_cnt++;
        m_pend[i] = (m_cnt != 0);
      end
      chk("pending", 32'(ts_mcycle_pending), 32'(m_pend));
      m_wv = 1'b0;
      m_wi = 0;
      foreach (q[k])
        if (q[k].s + ML == cyc && q[k].sq >= cyc) begin
          m_wv = 1'b1;
          m_wi = q[k].t;
        end
      chk("wb_valid", 32'(ts_wb_expect_valid), 32'(m_wv));
      if (m_wv) chk("wb_idx", 32'(ts_wb_expect_thread_idx), 32'(m_wi));
      if (m_g >= 0) begin
        rr = m_g;
        if (dest[m_g]) busy[cyc + (mc[m_g] ? ML : SL)] = 1'b1;
        if (mc[m_g]) q.push_back('{cyc, m_g, NEVER});
      end
      if (rb_en)
        foreach (q[k])
          if (q[k].t == int'(rb_idx) && q[k].s >= cyc - (ML - 1) && q[k].s <= cyc - 1 && q[k].sq == NEVER)
            q[k].sq = cyc;
      while (q.size() > 0 && q[0].s + ML < cyc) void'(q.pop_front());
    end
    cyc++;
  end

  task automatic apply(input logic [T-1:0] r, m, d, input logic rbe, input int rbi);
    @(posedge clk); #1;
    ready = r; mc = m; dest = d; rb_en = rbe; rb_idx = thread_idx_t'(rbi);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; ready = '0; mc = '0; dest = '0; rb_en = 1'b0; rb_idx = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin over all single-cycle requesters from reset.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(4'hF, 4'h0, 4'hF, 1'b0, 0);
      chk("s1_rr_idx", 32'(ts_grant_thread_idx), 32'(k % 4));
    end

    // Multi-cycle on thread 1 blocks thread 2's single-cycle op when writebacks collide.
    do_reset();
    apply(4'b0110, 4'b0010, 4'b0110, 1'b0, 0);
    chk("s2_mc_idx", 32'(ts_grant_thread_idx), 1);
    for (int k = 1; k <= 3; k++) begin
      apply(4'b0100, 4'b0000, 4'b0100, 1'b0, 0);
      chk("s2_t2_idx", 32'(ts_grant_thread_idx), 2);
    end
    apply(4'b1100, 4'b0000, 4'b0100, 1'b0, 0);
    chk("s2_t2_blocked", 32'(ts_grant_oh), 32'b1000);
    apply(4'b0100, 4'b0000, 4'b0100, 1'b0, 0);
    chk("s2_t2_after", 32'(ts_grant_thread_idx), 2);

    // Two back-to-back multi-cycle ops on thread 0.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 2) apply(4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
      else       apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
      chk("s3_pending0", 32'(ts_mcycle_pending[0]), 32'(c >= 1 && c <= 5));
      chk("s3_wb_valid", 32'(ts_wb_expect_valid), 32'(c == 5 || c == 6));
      if (c == 5 || c == 6) chk("s3_wb_idx", 32'(ts_wb_expect_thread_idx), 0);
    end

    // Rollback of thread 2 while its multi-cycle op is in flight.
    do_reset();
    apply(4'b0100, 4'b0100, 4'b0100, 1'b0, 0);
    chk("s4_mc_idx", 32'(ts_grant_thread_idx), 2);
    apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    apply(4'b0100, 4'b0100, 4'b0100, 1'b1, 2);
    chk("s4_rb_nogrant", 32'(ts_grant_valid), 0);
    apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    chk("s4_pending2", 32'(ts_mcycle_pending[2]), 0);
    apply(4'b0100, 4'b0000, 4'b0100, 1'b0, 0);
    chk("s4_slot_kept", 32'(ts_grant_valid), 0);
    apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    chk("s4_no_wb", 32'(ts_wb_expect_valid), 0);

    // Wrap-around and pointer hold.
    do_reset();
    apply(4'b1000, 4'b0000, 4'b0000, 1'b0, 0);
    chk("s5_wrap_idx", 32'(ts_grant_thread_idx), 3);
    apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    chk("s5_idle", 32'(ts_grant_valid), 0);
    apply(4'b1111, 4'b0000, 4'b0000, 1'b0, 0);
    chk("s5_hold_idx", 32'(ts_grant_thread_idx), 0);

    // Asynchronous reset with work in flight.
    do_reset();
    apply(4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
    apply(4'b0001, 4'b0001, 4'b0001, 1'b0, 0);
    @(posedge clk); #1;
    ready = 4'hF; mc = '0; dest = '0;
    #1;
    chk("s6_pre_pending", 32'(ts_mcycle_pending[0]), 1);
    #1 reset = 1'b0;
    #1;
    chk("s6_async_grant", 32'(ts_grant_oh), 0);
    chk("s6_async_pending", 32'(ts_mcycle_pending), 0);
    chk("s6_async_wb", 32'(ts_wb_expect_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1; ready = '0;
    for (int c = 0; c < 8; c++) begin
      apply(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
      chk("s6_no_wb", 32'(ts_wb_expect_valid), 0);
    end

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      apply(T'($urandom), T'($urandom), T'($urandom | $urandom),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, T - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
